data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder side of the load/store request interface driven by the memory-access stage. It accepts one request at a time over a valid/ready handshake, services it from an internal word-addressed RAM after a fixed latency, and returns the result on a valid/ready response channel. It handles RV32I byte/halfword/word sizing, sign extension and error detection, and it replaces the zero-latency combinational data memory once the core is pipelined.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the RAM; the valid byte range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from request acceptance to resp_valid. Legal range is 1..15.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_funct3  input  3  RV32I size code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_wdata  input  32  store data; the low bits are used for SB/SH.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load result after extension; 0 for stores and for errors.
- resp_err  output  1  request was misaligned, out of range, or had an illegal funct3.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid at a clock edge, capture write, addr, funct3 and wdata. Go to BUSY with the counter set to LATENCY-1, or go directly to RESP if LATENCY=1.
  - BUSY: req_ready=0. Decrement the counter each cycle. When the counter reaches 1, the next state is RESP. The access is performed on that transition.
  - RESP: resp_valid=1. Outputs hold stable until resp_valid && resp_ready at a clock edge, then go to IDLE.
- Access on entry to RESP:
  - Word index is addr[31:2].
  - Store: update only the byte lanes selected by addr[1:0] and the size. SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all lanes.
  - Load: select the byte or halfword at addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Error checks are evaluated on the captured request, and any error sets resp_err=1:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr[31:2] ≥ DEPTH_WORDS.
  - funct3 in {011,110,111}.
  - Store with funct3[2]=1.
- On error: no RAM write, and resp_rdata=0.
- RAM contents are not cleared by reset. Simulation initial contents are zero.

## Timing
- Reset (rst=0 at an edge) sets state=IDLE and counter=0. Resulting outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Reset during BUSY aborts the request: no RAM write occurs and no response is issued.
- Reset during RESP drops the response. A write already committed on entry to RESP remains committed.
- Latency: a request accepted at edge N gives resp_valid=1 in the cycle after edge N+LATENCY-1. resp_valid can be sampled at edge N+LATENCY at the earliest.
- req_ready is combinational from state only (state==IDLE). It never depends on req_valid.
- No same-cycle turnaround. After the response handshake at edge M, req_ready=1 from edge M, and the next request can be accepted at edge M+1 at the earliest. Peak throughput is one request per LATENCY+1 cycles.
- resp_ready held low keeps the block in RESP indefinitely with outputs stable. req_valid during BUSY/RESP is ignored and is not captured.
- Inputs may change freely after acceptance. Only the captured copy is used.
- Load after store to the same address returns the new data, because the store commits before the load is accepted.

## Test plan
- Reset, then SW to addr 0x10 with wdata 0xDEADBEEF, LATENCY=2 -> resp_valid 2 edges after accept, resp_err=0, resp_rdata=0. A following LW at 0x10 -> 0xDEADBEEF.
- After that word is stored: LB at 0x13 -> 0xFFFFFFDE; LBU at 0x13 -> 0x000000DE; LH at 0x10 -> 0xFFFFBEEF; LHU at 0x12 -> 0x0000DEAD.
- SB of 0x55 to 0x11, then LW at 0x10 -> 0xDEAD55EF. SH of 0x1234 to 0x12, then LW at 0x10 -> 0x123455EF.
- Error cases:
  - LW at 0x11 -> resp_err=1, rdata=0.
  - SH at 0x13 -> resp_err=1, memory unchanged.
  - LW at 4*DEPTH_WORDS -> resp_err=1.
  - funct3=011 -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err remain stable and req_ready stays 0. Raise resp_ready -> req_ready=1 after that edge.
- Reset mid-BUSY on an SW of 0xAAAAAAAA to 0x20 -> no response is issued; after reset, LW at 0x20 returns the old value (0).

Source files
------------

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Load/store responder with a word-addressed RAM, RV32I sizing,
//               sign extension, error detection and fixed response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_BUSY     = 2'd1;
    localparam logic [1:0]  S_RESP     = 2'd2;
    localparam int          c_AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH_WORDS);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [3:0]      r_cnt;
    logic            r_write;
    logic [31:0]     r_addr;
    logic [2:0]      r_funct3;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_a_write;
    logic [31:0]     w_a_addr;
    logic [2:0]      w_a_funct3;
    logic [31:0]     w_a_wdata;
    logic            w_err;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_word;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load;
    logic [31:0]     w_rdata;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata_al;
    logic            w_do_write;

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_next_state = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // With single-cycle latency the access happens on the accept edge, so
    // the live request must be used instead of the not-yet-captured copy.
    assign w_a_write  = (r_state == S_IDLE) ? req_write  : r_write;
    assign w_a_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_a_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
    assign w_a_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_err = (w_a_funct3 == 3'b011) || (w_a_funct3 == 3'b110) || (w_a_funct3 == 3'b111)
                || (w_a_write && w_a_funct3[2])
                || ((w_a_funct3[1:0] == 2'b01) && w_a_addr[0])
                || ((w_a_funct3[1:0] == 2'b10) && (w_a_addr[1:0] != 2'b00))
                || ({2'b00, w_a_addr[31:2]} >= c_DEPTH);

    assign w_idx     = w_a_addr[c_AW+1:2];
    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_a_addr[1:0], 3'b000};

    always_comb begin
        w_load = 32'd0;
        case (w_a_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = 32'd0;
        endcase
    end

    assign w_rdata = (w_a_write || w_err) ? 32'd0 : w_load;

    always_comb begin
        w_be       = 4'b0000;
        w_wdata_al = w_a_wdata;
        case (w_a_funct3[1:0])
            2'b00: begin
                w_be       = 4'b0001 << w_a_addr[1:0];
                w_wdata_al = {4{w_a_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = w_a_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{w_a_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // A reset on the commit edge aborts the store.
    assign w_do_write = rst && w_enter_resp && w_a_write && !w_err;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_al[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_funct3 <= 3'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
                r_cnt    <= c_CNT_INIT;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Self-checking bench: directed vector table, backpressure and
//               reset-abort sequences, then randomized traffic vs a byte model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [4*DEPTH];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-array reference: size from funct3, natural alignment, little-endian.
    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        logic [31:0] v;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        er = (size == 0) || (f3 == 3'b110) || (w && f3[2]) || (a / 4 >= DEPTH);
        if (size != 0 && (a % size) != 0) er = 1'b1;
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | ({24'd0, mb[a + i]} << (8 * i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                rd = v;
            end
        end
    endfunction

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int k;
        rd = 32'd0; er = 1'b0; lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (!req_ready) begin
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = $urandom; req_funct3 = 3'($urandom); req_wdata = $urandom;
        k = 1;
        while (!resp_valid && k < 50) begin @(negedge clk); k++; end
        if (!resp_valid) begin
            chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
            return;
        end
        lat = k;
        rd  = resp_rdata;
        er  = resp_err;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
        chk("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] rd, mrd, rd0;
        logic        er, mer;
        int          lat, k, r;
        logic        w;
        logic [31:0] a;
        logic [2:0]  f3;

        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'd0;

        vecs.push_back('{"sw_10",      1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{"lw_10",      1'b0, 32'h10,  3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"lb_13",      1'b0, 32'h13,  3'b000, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{"lbu_13",     1'b0, 32'h13,  3'b100, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{"lh_10",      1'b0, 32'h10,  3'b001, 32'h0,        32'hFFFFBEEF, 1'b0});
        vecs.push_back('{"lhu_12",     1'b0, 32'h12,  3'b101, 32'h0,        32'h0000DEAD, 1'b0});
        vecs.push_back('{"sb_11",      1'b1, 32'h11,  3'b000, 32'hFFFFFF55, 32'h0,        1'b0});
        vecs.push_back('{"lw_after_sb",1'b0, 32'h10,  3'b010, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{"sh_12",      1'b1, 32'h12,  3'b001, 32'hABCD1234, 32'h0,        1'b0});
        vecs.push_back('{"lw_after_sh",1'b0, 32'h10,  3'b010, 32'h0,        32'h123455EF, 1'b0});
        vecs.push_back('{"lw_mis_11",  1'b0, 32'h11,  3'b010, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"sh_mis_13",  1'b1, 32'h13,  3'b001, 32'h0000FFFF, 32'h0,        1'b1});
        vecs.push_back('{"lw_unchanged",1'b0,32'h10,  3'b010, 32'h0,        32'h123455EF, 1'b1 ^ 1'b1});
        vecs.push_back('{"lw_oor",     1'b0, 32'h400, 3'b010, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"f3_011",     1'b0, 32'h10,  3'b011, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"store_f3_4", 1'b1, 32'h10,  3'b100, 32'h11111111, 32'h0,        1'b1});
        vecs.push_back('{"lh_mis_11",  1'b0, 32'h11,  3'b001, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"lb_last",    1'b0, 32'h3FF, 3'b000, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"lw_last",    1'b0, 32'h3FC, 3'b010, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"lw_after_err",1'b0,32'h10,  3'b010, 32'h0,        32'h123455EF, 1'b0});

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            model(vecs[i].w, vecs[i].a, vecs[i].f3, vecs[i].wd, mrd, mer);
            do_txn(vecs[i].w, vecs[i].a, vecs[i].f3, vecs[i].wd, i % 3, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(LAT));
        end

        // Backpressure, with stray requests offered while the response waits
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 50) begin @(negedge clk); k++; end
        chk("bp_latency", 32'(k), 32'(LAT));
        rd0 = resp_rdata;
        chk("bp_rdata", rd0, 32'h123455EF);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010;
            req_wdata = $urandom;
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_rdata", resp_rdata, rd0);
            chk("bp_hold_err",   {31'd0, resp_err}, 32'd0);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_release_ready", {31'd0, req_ready},  32'd1);
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        do_txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat);
        chk("bp_ignored_req", rd, 32'h123455EF);

        // Reset while BUSY aborts the store and the response
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010;
        req_wdata = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("abort_ready",   {31'd0, req_ready},  32'd1);
            @(negedge clk);
        end
        do_txn(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er, lat);
        chk("abort_lw_20", rd, 32'h0);
        chk("abort_lw_20_err", {31'd0, er}, 32'd0);

        // Randomized traffic against the byte model
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            w = 1'($urandom_range(0, 1));
            if (r < 6)      a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'($urandom_range(0, 1023));
            else            a = $urandom;
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (w ? 3'd0 : 3'($urandom_range(0, 1)) << 2);
            model(w, a, f3, rd0, mrd, mer);
            do_txn(w, a, f3, rd0, int'($urandom_range(0, 2)), rd, er, lat);
            chk("rand_rdata",   rd, mrd);
            chk("rand_err",     {31'd0, er}, {31'd0, mer});
            chk("rand_latency", 32'(lat), 32'(LAT));
            rd0 = $urandom;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
